// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and control-vector field offsets for elastic pipeline stages
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Bit positions inside the ID/EX and EX/WB control vectors
    localparam int MEM_WRITE     = 0;
    localparam int ALU_SRC       = 1;
    localparam int ALU_REG_WRITE = 2;
    localparam int MEM_REG_WRITE = 3;
    localparam int LONG_WRITE    = 4;
    localparam int BRANCH        = 5;

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// rtl/pipe_stage_elastic_if.sv - valid/ready stream carrying payload and control bits
interface pipe_stage_elastic_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 8
);
    logic              valid;
    logic              ready;
    logic [WIDTH-1:0]  data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input ready);
    modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - payload+control register with load enable; control cleared on reset/flush
module pipe_entry_reg #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              load,
    input  logic [WIDTH-1:0]  next_data,
    input  logic [CTRL_W-1:0] next_ctrl,
    output logic [WIDTH-1:0]  data,
    output logic [CTRL_W-1:0] ctrl
);

    // Payload survives a flush; only the control bits carry meaning once squashed.
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
            ctrl <= '0;
        end else if (flush) begin
            ctrl <= '0;
        end else if (load) begin
            data <= next_data;
            ctrl <= next_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline stage, single register or 2-entry skid buffer
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 8,
    parameter bit SKID   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    pipe_stage_elastic_if.slave  up,
    pipe_stage_elastic_if.master down,
    output logic [1:0]           occupancy
);

    logic              in_fire;
    logic              out_fire;
    logic [WIDTH-1:0]  data_main;
    logic [CTRL_W-1:0] ctrl_main;

    assign in_fire   = up.valid & up.ready;
    assign out_fire  = down.valid & down.ready;
    assign down.data = data_main;
    assign down.ctrl = ctrl_main & {CTRL_W{down.valid}};

    if (SKID) begin : g_skid
        state_t            state;
        state_t            state_next;
        logic              ready_q;
        logic              main_load;
        logic              skid_load;
        logic [WIDTH-1:0]  data_skid;
        logic [CTRL_W-1:0] ctrl_skid;
        logic [WIDTH-1:0]  main_next_data;
        logic [CTRL_W-1:0] main_next_ctrl;

        always_comb begin
            state_next = state;
            main_load  = 1'b0;
            skid_load  = 1'b0;
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_next = ST_ONE;
                        main_load  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        state_next = ST_FULL;
                        skid_load  = 1'b1;
                    end else if (out_fire) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_next = ST_ONE;
                        main_load  = 1'b1;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
            // An output handshake in a flush cycle has already been taken downstream.
            if (flush) begin
                state_next = ST_EMPTY;
                main_load  = 1'b0;
                skid_load  = 1'b0;
            end
        end

        // in_ready is registered from the next state, cutting the ready path between stages.
        always_ff @(posedge clk) begin
            if (reset) begin
                state   <= ST_EMPTY;
                ready_q <= 1'b0;
            end else begin
                state   <= state_next;
                ready_q <= (state_next != ST_FULL);
            end
        end

        assign main_next_data = (state == ST_FULL) ? data_skid : up.data;
        assign main_next_ctrl = (state == ST_FULL) ? ctrl_skid : up.ctrl;

        pipe_entry_reg #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) u_main (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .load      (main_load),
            .next_data (main_next_data),
            .next_ctrl (main_next_ctrl),
            .data      (data_main),
            .ctrl      (ctrl_main)
        );

        pipe_entry_reg #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) u_skid (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .load      (skid_load),
            .next_data (up.data),
            .next_ctrl (up.ctrl),
            .data      (data_skid),
            .ctrl      (ctrl_skid)
        );

        assign up.ready   = ready_q;
        assign down.valid = (state != ST_EMPTY);
        assign occupancy  = state;
    end else begin : g_single
        logic valid_q;

        assign up.ready = !reset & (!valid_q | down.ready);

        always_ff @(posedge clk) begin
            if (reset || flush) begin
                valid_q <= 1'b0;
            end else if (in_fire) begin
                valid_q <= 1'b1;
            end else if (out_fire) begin
                valid_q <= 1'b0;
            end
        end

        pipe_entry_reg #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) u_main (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .load      (in_fire),
            .next_data (up.data),
            .next_ctrl (up.ctrl),
            .data      (data_main),
            .ctrl      (ctrl_main)
        );

        assign down.valid = valid_q;
        assign occupancy  = {1'b0, valid_q};
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - randomized and directed checks of both stage modes against a queue model
module tb_pipe_stage_elastic;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  c;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush1;
    logic       flush0;
    logic [1:0] occ1;
    logic [1:0] occ0;

    pipe_stage_elastic_if #(.WIDTH(32), .CTRL_W(8)) up1 ();
    pipe_stage_elastic_if #(.WIDTH(32), .CTRL_W(8)) dn1 ();
    pipe_stage_elastic_if #(.WIDTH(32), .CTRL_W(8)) up0 ();
    pipe_stage_elastic_if #(.WIDTH(32), .CTRL_W(8)) dn0 ();

    pipe_stage_elastic #(.WIDTH(32), .CTRL_W(8), .SKID(1'b1)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush1),
        .up        (up1),
        .down      (dn1),
        .occupancy (occ1)
    );

    pipe_stage_elastic #(.WIDTH(32), .CTRL_W(8), .SKID(1'b0)) u_reg (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush0),
        .up        (up0),
        .down      (dn0),
        .occupancy (occ0)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    ent_t q1[$];
    ent_t q0[$];
    int   delivered1 = 0;
    int   delivered0 = 0;
    bit   started = 1'b0;
    bit   after_rst1 = 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the skid-mode stage; the model is a FIFO of at most two entries.
    task automatic step1(input bit rst, input bit v, input logic [31:0] d, input logic [7:0] c,
                         input bit ordy, input bit fl, output bit infire);
        bit ev;
        bit er;
        bit ofire;
        reset = rst;
        up1.valid = v; up1.data = d; up1.ctrl = c; dn1.ready = ordy; flush1 = fl;
        up0.valid = 1'b0; dn0.ready = 1'b0; flush0 = 1'b0;
        @(negedge clk);
        ev = (q1.size() > 0);
        er = !rst && !after_rst1 && (q1.size() < 2);
        if (started) begin
            check("s1_in_ready", up1.ready, er);
            check("s1_out_valid", dn1.valid, ev);
            check("s1_occupancy", occ1, q1.size());
            check("s1_out_ctrl", dn1.ctrl, ev ? q1[0].c : 8'h00);
            if (ev) check("s1_out_data", dn1.data, q1[0].d);
        end
        infire = er && v;
        ofire = ev && ordy;
        @(posedge clk);
        if (rst) begin
            q1.delete();
            after_rst1 = 1'b1;
            started = 1'b1;
        end else begin
            after_rst1 = 1'b0;
            if (ofire) begin
                void'(q1.pop_front());
                delivered1++;
            end
            if (fl) q1.delete();
            else if (infire) q1.push_back({d, c});
        end
        #1;
    endtask

    // One clock of the single-register stage; the model holds at most one entry.
    task automatic step0(input bit v, input logic [31:0] d, input logic [7:0] c,
                         input bit ordy, output bit infire);
        bit ev;
        bit er;
        bit ofire;
        reset = 1'b0;
        up0.valid = v; up0.data = d; up0.ctrl = c; dn0.ready = ordy; flush0 = 1'b0;
        up1.valid = 1'b0; dn1.ready = 1'b0; flush1 = 1'b0;
        @(negedge clk);
        ev = (q0.size() > 0);
        er = !ev || ordy;
        check("s0_in_ready", up0.ready, er);
        check("s0_out_valid", dn0.valid, ev);
        check("s0_occupancy", occ0, q0.size());
        check("s0_out_ctrl", dn0.ctrl, ev ? q0[0].c : 8'h00);
        if (ev) check("s0_out_data", dn0.data, q0[0].d);
        infire = er && v;
        ofire = ev && ordy;
        @(posedge clk);
        if (ofire) begin
            void'(q0.pop_front());
            delivered0++;
        end
        if (infire) q0.push_back({d, c});
        #1;
    endtask

    task automatic send1(input logic [31:0] d, input logic [7:0] c, input bit ordy);
        bit f;
        int n;
        f = 1'b0;
        n = 0;
        while (!f && n < 20) begin
            step1(1'b0, 1'b1, d, c, ordy, 1'b0, f);
            n++;
        end
        check("send1_accepted", f, 1'b1);
    endtask

    initial begin
        bit          f;
        int          idx;
        int          cyc;
        int          d0;
        logic [31:0] rd;
        logic [7:0]  rc;

        reset = 1'b1; flush1 = 1'b0; flush0 = 1'b0;
        up1.valid = 1'b0; up1.data = '0; up1.ctrl = '0; dn1.ready = 1'b0;
        up0.valid = 1'b0; up0.data = '0; up0.ctrl = '0; dn0.ready = 1'b0;
        @(posedge clk);
        #1;

        step1(1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, f);
        step1(1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, f);

        idx = 1;
        cyc = 0;
        while (delivered1 < 8 && cyc < 50) begin
            step1(1'b0, idx <= 8, idx, 8'h01, 1'b1, 1'b0, f);
            if (f) idx++;
            cyc++;
        end
        check("stream_delivered", delivered1, 8);
        check("stream_cycles", cyc, 10);

        send1(32'hA, 8'h11, 1'b0);
        send1(32'hB, 8'h22, 1'b0);
        step1(1'b0, 1'b1, 32'hD, 8'h33, 1'b0, 1'b0, f);
        step1(1'b0, 1'b1, 32'hD, 8'h33, 1'b0, 1'b0, f);
        check("bp_occupancy", occ1, 2);
        check("bp_in_ready", up1.ready, 1'b0);
        check("bp_hold_data", dn1.data, 32'hA);
        step1(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, f);
        check("drain_in_ready", up1.ready, 1'b1);
        check("drain_second", dn1.data, 32'hB);
        step1(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, f);

        send1(32'hA, 8'h11, 1'b0);
        send1(32'hB, 8'h22, 1'b0);
        step1(1'b0, 1'b1, 32'hC, 8'hFF, 1'b0, 1'b1, f);
        check("flush_out_valid", dn1.valid, 1'b0);
        check("flush_out_ctrl", dn1.ctrl, 8'h00);
        check("flush_occupancy", occ1, 0);
        check("flush_in_ready", up1.ready, 1'b1);
        for (int i = 0; i < 3; i++) step1(1'b0, 1'b0, 32'hC, 8'hFF, 1'b1, 1'b0, f);

        send1(32'h5, 8'h05, 1'b0);
        d0 = delivered1;
        step1(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 1'b1, f);
        check("flush_hs_delivered", delivered1, d0 + 1);
        for (int i = 0; i < 3; i++) step1(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, f);

        for (int i = 0; i < 5; i++) begin
            step1(1'b0, 1'b0, $urandom, 8'hFF, 1'b0, 1'b0, f);
            check("bubble_ctrl", dn1.ctrl, 8'h00);
            check("bubble_valid", dn1.valid, 1'b0);
        end

        for (int i = 0; i < 400; i++) begin
            rd = $urandom;
            rc = 8'($urandom_range(1, 255));
            step1(1'b0, $urandom_range(0, 3) != 0, rd, rc, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 40) == 0, f);
        end
        for (int i = 0; i < 4; i++) step1(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, f);
        check("skid_random_drained", q1.size(), 0);

        idx = 0;
        cyc = 0;
        rd = $urandom;
        rc = 8'($urandom_range(1, 255));
        while ((idx < 1000 || q0.size() > 0) && cyc < 20000) begin
            step0(idx < 1000 && $urandom_range(0, 2) != 0, rd, rc, $urandom_range(0, 2) != 0, f);
            if (f) begin
                idx++;
                rd = $urandom;
                rc = 8'($urandom_range(1, 255));
            end
            cyc++;
        end
        check("reg_sent", idx, 1000);
        check("reg_delivered", delivered0, 1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, generalised pipeline register that replaces fixed-field stage registers with a valid/ready elastic stage.
- Carries an opaque data payload and a control-bit vector.
- Control bits are squashed to zero on flush or bubble, so hazard logic never needs per-field resets.
- Optional 2-entry skid mode gives full throughput with a registered in_ready, so the ready path is cut between stages.

Parameters:
- WIDTH, 32: payload bits (pc, operands, imm, alu result, ...), passed through unmodified.
- CTRL_W, 8: control bits (reg_write, mem_write, branch, ...), forced to 0 when the stage holds no valid entry.
- SKID, 1: 1 selects 2-entry skid buffer with registered in_ready; 0 selects single register with combinational in_ready.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept
- in_data  in  WIDTH  payload
- in_ctrl  in  CTRL_W  control bits
- out_valid  out  1  entry available downstream
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  payload of head entry
- out_ctrl  out  CTRL_W  control of head entry; 0 when out_valid=0
- occupancy  out  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Transfer in: in_valid & in_ready at clk edge. Transfer out: out_valid & out_ready at clk edge.
- Latency: 1 cycle from input transfer to out_valid. Sustained throughput: 1 entry/cycle in both modes.
- Ordering: strict FIFO. No entry is duplicated or dropped except by flush or reset.
- Reset (priority 1), values:
  - out_valid=0, occupancy=0, out_ctrl=0.
  - Main and skid ctrl regs cleared; data regs cleared to 0.
  - in_ready: SKID=1 gives 0 during reset and in the first cycle after reset deasserts, then 1. SKID=0 gives 0 while reset is high.
- Flush (priority 2):
  - State goes to EMPTY; ctrl regs cleared; data regs keep their value (don't-care).
  - An input transfer in a flush cycle is dropped.
  - An output transfer in a flush cycle completes normally, since downstream has already sampled it.
  - SKID=1: in_ready is 1 in the cycle after flush.
- out_ctrl = ctrl_main & {CTRL_W{out_valid}}. It is never nonzero with out_valid low, so this is the bubble guarantee.
- SKID=1 FSM, registers main and skid:
  - EMPTY (in_ready=1, out_valid=0): in leads to ONE, with main<=in.
  - ONE (in_ready=1, out_valid=1):
    - in & !out leads to FULL, with skid<=in.
    - out & !in leads to EMPTY.
    - in & out stays ONE, with main<=in.
    - neither: hold.
  - FULL (in_ready=0, out_valid=1):
    - out leads to ONE, with main<=skid.
    - otherwise hold. No input is possible.
  - in_ready is a flop: next = (next_state != FULL) & !reset.
  - occupancy = 0/1/2 for EMPTY/ONE/FULL.
- SKID=0:
  - in_ready = !reset & (!out_valid | out_ready), combinational.
  - In a simultaneous in/out cycle, the register reloads and stays valid.
- Stall: out_ready=0 holds out_data/out_ctrl stable while out_valid=1. This is mandatory and verified by assertion.
- Upstream rule: in_data/in_ctrl are sampled only on transfer. in_valid may drop without a transfer.

Decomposition:
- Shared package pipe_pkg holds:
  - localparams for the state encoding (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2);
  - standard CTRL_W field offsets for the ID/EX and EX/WB control vectors (MEM_WRITE, ALU_SRC, ALU_REG_WRITE, MEM_REG_WRITE, LONG_WRITE, BRANCH).
- One natural sub-module, pipe_entry_reg. It is a WIDTH+CTRL_W register with load enable, plus ctrl clear on reset/flush.
  - Instantiated once for SKID=0.
  - Instantiated twice (main, skid) for SKID=1.
- FSM and handshake logic live in the top module.

Test Plan:
- Reset then stream (SKID=1):
  - Stimulus: assert reset 2 cycles, release; hold in_valid=1 and out_ready=1; send data 0x1..0x8 with ctrl 0x01.
  - Required: in_ready=0 until the 2nd post-reset cycle; out emits 0x1..0x8 in order, one per cycle, first one 1 cycle after the first transfer; occupancy stays 1.
- Backpressure fill (SKID=1):
  - Stimulus: out_ready=0; send 0xA then 0xB.
  - Required: occupancy goes to 2, in_ready=0, out_data holds 0xA stable.
  - Then raise out_ready for 2 cycles. Required: 0xA then 0xB; in_ready=1 one cycle after the first drain.
- Flush while FULL:
  - Stimulus: with 0xA/0xB held, pulse flush with in_valid=1, data 0xC.
  - Required next cycle: out_valid=0, out_ctrl=0, occupancy=0; 0xC never appears at the output.
- Flush with output handshake:
  - Stimulus: ONE state holding 0x5, out_ready=1, flush=1 in the same cycle.
  - Required: 0x5 is counted as delivered by the scoreboard; no further entries are output.
- Bubble masking:
  - Stimulus: drive in_ctrl=0xFF while in_valid=0 for 5 cycles.
  - Required: out_ctrl=0x00 throughout, out_valid=0.
- SKID=0 mode:
  - Stimulus: random in_valid/out_ready, 1000 entries.
  - Required: in-order delivery with none lost; occupancy ≤1; in_ready equals !out_valid|out_ready every cycle.
